// File: rtl/int8_tile_scheduler_if.sv
// Control bundle between int8_tile_scheduler (master) and its ap_*/feeder/engine environment (slave).
// TILE_SCHED_PERF_EN adds the perf_busy / perf_tiles counter outputs.
interface int8_tile_scheduler_if #(
    parameter int TW = 3
`ifdef TILE_SCHED_PERF_EN
    , parameter int PERF_W = 32
`endif
);
    logic          ap_start;
    logic          ap_idle;
    logic          ap_ready;
    logic          ap_done;
    logic          ap_continue;
    logic [TW-1:0] cfg_m_tiles;
    logic [TW-1:0] cfg_n_tiles;
    logic [TW-1:0] cfg_k_tiles;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [TW-1:0] cmd_i;
    logic [TW-1:0] cmd_j;
    logic [TW-1:0] cmd_k;
    logic          cmd_first_k;
    logic          cmd_last_k;
    logic          eng_start;
    logic          eng_done;
    logic          eng_continue;
    logic          err_spurious;
`ifdef TILE_SCHED_PERF_EN
    logic [PERF_W-1:0] perf_busy;
    logic [15:0]       perf_tiles;
`endif

    modport master (
        input  ap_start, ap_continue, cfg_m_tiles, cfg_n_tiles, cfg_k_tiles,
        input  cmd_ready, eng_done,
        output ap_idle, ap_ready, ap_done,
        output cmd_valid, cmd_i, cmd_j, cmd_k, cmd_first_k, cmd_last_k,
        output eng_start, eng_continue, err_spurious
`ifdef TILE_SCHED_PERF_EN
        , output perf_busy, perf_tiles
`endif
    );

    modport slave (
        output ap_start, ap_continue, cfg_m_tiles, cfg_n_tiles, cfg_k_tiles,
        output cmd_ready, eng_done,
        input  ap_idle, ap_ready, ap_done,
        input  cmd_valid, cmd_i, cmd_j, cmd_k, cmd_first_k, cmd_last_k,
        input  eng_start, eng_continue, err_spurious
`ifdef TILE_SCHED_PERF_EN
        , input perf_busy, perf_tiles
`endif
    );
endinterface

// File: rtl/int8_tile_scheduler.sv
// Walks (i,j,k) tile tuples (k innermost) and runs the issue/start/wait handshake of one tile engine.
// Optional busy-cycle and tile counters are built when TILE_SCHED_PERF_EN is defined.
module int8_tile_scheduler #(
    parameter int TW = 3
`ifdef TILE_SCHED_PERF_EN
    , parameter int PERF_W = 32
`endif
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    int8_tile_scheduler_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] cfg_m_q, cfg_m_d;
    logic [TW-1:0] cfg_n_q, cfg_n_d;
    logic [TW-1:0] cfg_k_q, cfg_k_d;
    logic [TW-1:0] i_q, i_d;
    logic [TW-1:0] j_q, j_d;
    logic [TW-1:0] k_q, k_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          first_k_q, first_k_d;
    logic          last_k_q, last_k_d;
    logic          eng_start_q, eng_start_d;
    logic          eng_continue_q, eng_continue_d;
    logic          ap_idle_q, ap_idle_d;
    logic          ap_done_q, ap_done_d;
    logic          err_q, err_d;

    logic accept;
    logic eng_ack;
    logic last_tuple;

    assign accept     = (state_q == S_IDLE) && bus.ap_start;
    assign eng_ack    = (state_q == S_WAIT) && bus.eng_done;
    assign last_tuple = (i_q == cfg_m_q) && (j_q == cfg_n_q) && (k_q == cfg_k_q);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.ap_start)    state_d = S_ISSUE;
            S_ISSUE: if (bus.cmd_ready)   state_d = S_START;
            S_START:                      state_d = S_WAIT;
            S_WAIT:  if (bus.eng_done)    state_d = last_tuple ? S_DONE : S_ISSUE;
            S_DONE:  if (bus.ap_continue) state_d = S_IDLE;
            default:                      state_d = S_IDLE;
        endcase
    end

    // Index walk: all three counters wrap together on the last tuple, leaving (0,0,0).
    always_comb begin
        cfg_m_d = cfg_m_q;
        cfg_n_d = cfg_n_q;
        cfg_k_d = cfg_k_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        err_d   = err_q;
        if (accept) begin
            cfg_m_d = bus.cfg_m_tiles;
            cfg_n_d = bus.cfg_n_tiles;
            cfg_k_d = bus.cfg_k_tiles;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            err_d   = 1'b0;
        end
        if (eng_ack) begin
            if (k_q == cfg_k_q) begin
                k_d = '0;
                if (j_q == cfg_n_q) begin
                    j_d = '0;
                    i_d = (i_q == cfg_m_q) ? '0 : i_q + TW'(1);
                end else begin
                    j_d = j_q + TW'(1);
                end
            end else begin
                k_d = k_q + TW'(1);
            end
        end
        if (bus.eng_done && (state_q != S_WAIT)) begin
            err_d = 1'b1;
        end
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_comb begin
        ap_idle_d      = (state_d == S_IDLE);
        ap_done_d      = (state_d == S_DONE);
        cmd_valid_d    = (state_d == S_ISSUE);
        eng_start_d    = (state_d == S_START);
        eng_continue_d = eng_ack;
        first_k_d      = (k_d == '0);
        last_k_d       = (k_d == cfg_k_d);
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            cfg_m_q        <= '0;
            cfg_n_q        <= '0;
            cfg_k_q        <= '0;
            i_q            <= '0;
            j_q            <= '0;
            k_q            <= '0;
            err_q          <= 1'b0;
            ap_idle_q      <= 1'b1;
            ap_done_q      <= 1'b0;
            cmd_valid_q    <= 1'b0;
            eng_start_q    <= 1'b0;
            eng_continue_q <= 1'b0;
            first_k_q      <= 1'b0;
            last_k_q       <= 1'b0;
        end else begin
            cfg_m_q        <= cfg_m_d;
            cfg_n_q        <= cfg_n_d;
            cfg_k_q        <= cfg_k_d;
            i_q            <= i_d;
            j_q            <= j_d;
            k_q            <= k_d;
            err_q          <= err_d;
            ap_idle_q      <= ap_idle_d;
            ap_done_q      <= ap_done_d;
            cmd_valid_q    <= cmd_valid_d;
            eng_start_q    <= eng_start_d;
            eng_continue_q <= eng_continue_d;
            first_k_q      <= first_k_d;
            last_k_q       <= last_k_d;
        end
    end

    assign bus.ap_idle      = ap_idle_q;
    assign bus.ap_ready     = ap_idle_q;
    assign bus.ap_done      = ap_done_q;
    assign bus.cmd_valid    = cmd_valid_q;
    assign bus.cmd_i        = i_q;
    assign bus.cmd_j        = j_q;
    assign bus.cmd_k        = k_q;
    assign bus.cmd_first_k  = first_k_q;
    assign bus.cmd_last_k   = last_k_q;
    assign bus.eng_start    = eng_start_q;
    assign bus.eng_continue = eng_continue_q;
    assign bus.err_spurious = err_q;

`ifdef TILE_SCHED_PERF_EN
    logic [PERF_W-1:0] perf_busy_q, perf_busy_d;
    logic [15:0]       perf_tiles_q, perf_tiles_d;
    logic              busy_state;

    assign busy_state = (state_q == S_ISSUE) || (state_q == S_START) || (state_q == S_WAIT);

    always_comb begin
        perf_busy_d  = perf_busy_q;
        perf_tiles_d = perf_tiles_q;
        if (accept) begin
            perf_busy_d  = '0;
            perf_tiles_d = '0;
        end else begin
            if (busy_state && (perf_busy_q != {PERF_W{1'b1}})) begin
                perf_busy_d = perf_busy_q + PERF_W'(1);
            end
            if (eng_ack) begin
                perf_tiles_d = perf_tiles_q + 16'd1;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            perf_busy_q  <= '0;
            perf_tiles_q <= '0;
        end else begin
            perf_busy_q  <= perf_busy_d;
            perf_tiles_q <= perf_tiles_d;
        end
    end

    assign bus.perf_busy  = perf_busy_q;
    assign bus.perf_tiles = perf_tiles_q;
`endif
endmodule
